usb_pkt_decode: RTL and testbench



---
 rtl/usb_pkt_decode_if.sv | 40 ++++
 rtl/usb_pkt_decode.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_usb_pkt_decode.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/usb_pkt_decode_if.sv
// usb_pkt_decode_if: bundles the ULPI RX byte stream and the decoder's event, token-field and
// payload outputs.
//   master : drives rx_* (ULPI side / testbench) and observes the decoder outputs
//   slave  : the decoder; consumes rx_* and drives every *_o signal
interface usb_pkt_decode_if;
    logic        rx_tvalid_i;
    logic        rx_tlast_i;
    logic        rx_error_i;
    logic [7:0]  rx_tdata_i;

    logic [3:0]  usb_pid_o;
    logic        tok_recv_o;
    logic        tok_ping_o;
    logic [6:0]  tok_addr_o;
    logic [3:0]  tok_endp_o;
    logic        sof_recv_o;
    logic [10:0] sof_frame_o;
    logic        hsk_recv_o;
    logic        usb_recv_o;
    logic        crc_error_o;
    logic        len_error_o;
    logic        eop_recv_o;
    logic        dat_tvalid_o;
    logic        dat_tlast_o;
    logic [7:0]  dat_tdata_o;

    modport master (
        output rx_tvalid_i, rx_tlast_i, rx_error_i, rx_tdata_i,
        input  usb_pid_o, tok_recv_o, tok_ping_o, tok_addr_o, tok_endp_o, sof_recv_o,
               sof_frame_o, hsk_recv_o, usb_recv_o, crc_error_o, len_error_o, eop_recv_o,
               dat_tvalid_o, dat_tlast_o, dat_tdata_o
    );

    modport slave (
        input  rx_tvalid_i, rx_tlast_i, rx_error_i, rx_tdata_i,
        output usb_pid_o, tok_recv_o, tok_ping_o, tok_addr_o, tok_endp_o, sof_recv_o,
               sof_frame_o, hsk_recv_o, usb_recv_o, crc_error_o, len_error_o, eop_recv_o,
               dat_tvalid_o, dat_tlast_o, dat_tdata_o
    );
endinterface

// File: rtl/usb_pkt_decode.sv
// usb_pkt_decode: receive-side USB packet decoder. Validates the PID, classifies the packet,
// checks CRC5 on tokens and CRC16 on DATAx, extracts token/SOF fields and forwards DATAx
// payload with the two CRC bytes stripped. All event strobes are registered and appear the
// cycle after the tlast byte, together with eop_recv_o.
// Ports:
//   clock   : 60 MHz ULPI-domain clock
//   reset_n : asynchronous active-low reset
//   bus     : usb_pkt_decode_if.slave (rx_* byte stream in, events/fields/payload out)
module usb_pkt_decode #(
    parameter int unsigned MAX_PACKET = 512
) (
    input logic             clock,
    input logic             reset_n,
    usb_pkt_decode_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_TOK1, ST_TOK2, ST_DATA, ST_HSK, ST_DROP
    } state_e;

    localparam logic [9:0]  MaxCnt   = MAX_PACKET[9:0];
    localparam logic [4:0]  Crc5Res  = 5'b01100;
    localparam logic [15:0] Crc16Res = 16'h800D;

    // LSB-first serial CRCs, one byte per call.
    function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
        logic [4:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (d[i] ^ r[4]) r = {r[3:0], 1'b0} ^ 5'h05;
            else             r = {r[3:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (d[i] ^ r[15]) r = {r[14:0], 1'b0} ^ 16'h8005;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  pid_q, pid_d;
    logic [6:0]  addr_q, addr_d;
    logic [3:0]  endp_q, endp_d;
    logic [10:0] frame_q, frame_d;
    logic [4:0]  crc5_q, crc5_d;
    logic [15:0] crc16_q, crc16_d;
    logic [7:0]  b1_q, b1_d;          // first token field byte
    logic [7:0]  s0_q, s0_d;          // skid: newest byte
    logic [7:0]  s1_q, s1_d;          // skid: older byte, next to emit
    logic [1:0]  fill_q, fill_d;
    logic [9:0]  pay_cnt_q, pay_cnt_d;
    logic        err_q, err_d;        // rx_error_i seen earlier in this packet
    logic        len_bad_q, len_bad_d;

    logic        tok_q, tok_d, ping_q, ping_d, sof_q, sof_d, hsk_q, hsk_d;
    logic        usb_q, usb_d, crc_q, crc_d, len_q, len_d, eop_q, eop_d;
    logic        dvalid_q, dvalid_d, dlast_q, dlast_d;
    logic [7:0]  ddata_q, ddata_d;

    logic        err_pkt, pid_ok, too_short, too_long, crc_bad;
    logic [4:0]  crc5_nx;
    logic [15:0] crc16_nx;

    always_comb begin
        state_d   = state_q;
        pid_d     = pid_q;
        addr_d    = addr_q;
        endp_d    = endp_q;
        frame_d   = frame_q;
        crc5_d    = crc5_q;
        crc16_d   = crc16_q;
        b1_d      = b1_q;
        s0_d      = s0_q;
        s1_d      = s1_q;
        fill_d    = fill_q;
        pay_cnt_d = pay_cnt_q;
        err_d     = err_q;
        len_bad_d = len_bad_q;
        tok_d     = 1'b0;
        ping_d    = 1'b0;
        sof_d     = 1'b0;
        hsk_d     = 1'b0;
        usb_d     = 1'b0;
        crc_d     = 1'b0;
        len_d     = 1'b0;
        eop_d     = 1'b0;
        dvalid_d  = 1'b0;
        dlast_d   = 1'b0;
        ddata_d   = ddata_q;
        err_pkt   = err_q | bus.rx_error_i;
        pid_ok    = (bus.rx_tdata_i[7:4] == ~bus.rx_tdata_i[3:0]);
        too_short = 1'b0;
        too_long  = 1'b0;
        crc_bad   = 1'b0;
        crc5_nx   = crc5_byte(crc5_q, bus.rx_tdata_i);
        crc16_nx  = crc16_byte(crc16_q, bus.rx_tdata_i);

        if (bus.rx_tvalid_i) begin
            err_d = err_pkt;
            unique case (state_q)
                ST_IDLE: begin
                    crc5_d    = 5'h1F;
                    crc16_d   = 16'hFFFF;
                    fill_d    = 2'd0;
                    pay_cnt_d = 10'd0;
                    len_bad_d = 1'b0;
                    if (!pid_ok) begin
                        state_d = ST_DROP;
                    end else begin
                        pid_d = bus.rx_tdata_i[3:0];
                        case (bus.rx_tdata_i[3:0])
                            4'h1, 4'h9, 4'h5, 4'hD, 4'h4: begin
                                state_d = ST_TOK1;
                                len_d   = bus.rx_tlast_i;
                            end
                            4'h3, 4'hB, 4'h7, 4'hF: begin
                                state_d = ST_DATA;
                                len_d   = bus.rx_tlast_i;
                            end
                            4'h2, 4'hA, 4'hE, 4'h6: begin
                                state_d = ST_HSK;
                                hsk_d   = bus.rx_tlast_i;
                            end
                            default: state_d = ST_DROP;
                        endcase
                    end
                end
                ST_TOK1: begin
                    crc5_d  = crc5_nx;
                    b1_d    = bus.rx_tdata_i;
                    state_d = ST_TOK2;
                    len_d   = bus.rx_tlast_i;
                end
                ST_TOK2: begin
                    if (bus.rx_tlast_i) begin
                        if (crc5_nx == Crc5Res) begin
                            if (!err_pkt) begin
                                if (pid_q == 4'h5) begin
                                    frame_d = {bus.rx_tdata_i[2:0], b1_q};
                                    sof_d   = 1'b1;
                                end else begin
                                    addr_d = b1_q[6:0];
                                    endp_d = {bus.rx_tdata_i[2:0], b1_q[7]};
                                    tok_d  = 1'b1;
                                    ping_d = (pid_q == 4'h4);
                                end
                            end
                        end else begin
                            crc_d = 1'b1;
                        end
                    end else begin
                        // Token overran three bytes: report at its tlast.
                        len_bad_d = 1'b1;
                        state_d   = ST_DROP;
                    end
                end
                ST_DATA: begin
                    crc16_d = crc16_nx;
                    s0_d    = bus.rx_tdata_i;
                    s1_d    = s0_q;
                    if (fill_q != 2'd2) begin
                        fill_d = fill_q + 2'd1;
                    end else begin
                        // s1 is payload only once two newer bytes exist.
                        if (pay_cnt_q < MaxCnt) begin
                            dvalid_d = 1'b1;
                            ddata_d  = s1_q;
                            dlast_d  = bus.rx_tlast_i;
                        end
                        too_long = (pay_cnt_q >= MaxCnt);
                        if (pay_cnt_q != 10'h3FF) pay_cnt_d = pay_cnt_q + 10'd1;
                    end
                    if (bus.rx_tlast_i) begin
                        too_short = (fill_q == 2'd0);
                        crc_bad   = (crc16_nx != Crc16Res);
                        if (too_short) begin
                            len_d = 1'b1;
                        end else begin
                            len_d = too_long;
                            crc_d = crc_bad;
                            usb_d = !too_long && !crc_bad;
                        end
                    end
                end
                ST_HSK:  len_d = bus.rx_tlast_i;
                ST_DROP: len_d = bus.rx_tlast_i && len_bad_q;
                default: state_d = ST_IDLE;
            endcase

            if (bus.rx_tlast_i) begin
                state_d   = ST_IDLE;
                eop_d     = 1'b1;
                err_d     = 1'b0;
                len_bad_d = 1'b0;
                // A packet with an RxError reports only the CRC error.
                if (err_pkt) begin
                    tok_d  = 1'b0;
                    ping_d = 1'b0;
                    sof_d  = 1'b0;
                    hsk_d  = 1'b0;
                    usb_d  = 1'b0;
                    len_d  = 1'b0;
                    crc_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            pid_q     <= 4'h0;
            addr_q    <= 7'h0;
            endp_q    <= 4'h0;
            frame_q   <= 11'h0;
            crc5_q    <= 5'h1F;
            crc16_q   <= 16'hFFFF;
            b1_q      <= 8'h0;
            s0_q      <= 8'h0;
            s1_q      <= 8'h0;
            fill_q    <= 2'd0;
            pay_cnt_q <= 10'd0;
            err_q     <= 1'b0;
            len_bad_q <= 1'b0;
            tok_q     <= 1'b0;
            ping_q    <= 1'b0;
            sof_q     <= 1'b0;
            hsk_q     <= 1'b0;
            usb_q     <= 1'b0;
            crc_q     <= 1'b0;
            len_q     <= 1'b0;
            eop_q     <= 1'b0;
            dvalid_q  <= 1'b0;
            dlast_q   <= 1'b0;
            ddata_q   <= 8'h0;
        end else begin
            state_q   <= state_d;
            pid_q     <= pid_d;
            addr_q    <= addr_d;
            endp_q    <= endp_d;
            frame_q   <= frame_d;
            crc5_q    <= crc5_d;
            crc16_q   <= crc16_d;
            b1_q      <= b1_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            fill_q    <= fill_d;
            pay_cnt_q <= pay_cnt_d;
            err_q     <= err_d;
            len_bad_q <= len_bad_d;
            tok_q     <= tok_d;
            ping_q    <= ping_d;
            sof_q     <= sof_d;
            hsk_q     <= hsk_d;
            usb_q     <= usb_d;
            crc_q     <= crc_d;
            len_q     <= len_d;
            eop_q     <= eop_d;
            dvalid_q  <= dvalid_d;
            dlast_q   <= dlast_d;
            ddata_q   <= ddata_d;
        end
    end

    assign bus.usb_pid_o    = pid_q;
    assign bus.tok_recv_o   = tok_q;
    assign bus.tok_ping_o   = ping_q;
    assign bus.tok_addr_o   = addr_q;
    assign bus.tok_endp_o   = endp_q;
    assign bus.sof_recv_o   = sof_q;
    assign bus.sof_frame_o  = frame_q;
    assign bus.hsk_recv_o   = hsk_q;
    assign bus.usb_recv_o   = usb_q;
    assign bus.crc_error_o  = crc_q;
    assign bus.len_error_o  = len_q;
    assign bus.eop_recv_o   = eop_q;
    assign bus.dat_tvalid_o = dvalid_q;
    assign bus.dat_tlast_o  = dlast_q;
    assign bus.dat_tdata_o  = ddata_q;

endmodule

// File: tb/tb_usb_pkt_decode.sv
// tb_usb_pkt_decode: directed self-checking bench for usb_pkt_decode. Inputs change on the
// falling edge; outputs are sampled on the falling edge. Event strobes are packed as
// {tok_recv, tok_ping, sof_recv, hsk_recv, usb_recv, crc_error, len_error, eop_recv}.
module tb_usb_pkt_decode;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    usb_pkt_decode_if bus ();

    usb_pkt_decode #(.MAX_PACKET(512)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] pkt[$];
    logic [7:0] dat_q[$];
    int         tlast_cnt = 0;
    int         tlast_idx = -1;
    int         base;
    int         tl0;
    logic [7:0] setup_pay[8] = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};

    // Payload collector.
    always @(negedge clk) begin
        if (rst_n && bus.dat_tvalid_o) begin
            dat_q.push_back(bus.dat_tdata_o);
            if (bus.dat_tlast_o) begin
                tlast_cnt++;
                tlast_idx = dat_q.size() - 1;
            end
        end
    end

    function automatic logic [7:0] ev();
        return {bus.tok_recv_o, bus.tok_ping_o, bus.sof_recv_o, bus.hsk_recv_o,
                bus.usb_recv_o, bus.crc_error_o, bus.len_error_o, bus.eop_recv_o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive pkt one byte per cycle; err_idx marks the byte carrying rx_error_i.
    task automatic send(input int err_idx, input bit with_last);
        for (int i = 0; i < pkt.size(); i++) begin
            @(negedge clk);
            bus.rx_tvalid_i = 1'b1;
            bus.rx_tdata_i  = pkt[i];
            bus.rx_tlast_i  = with_last && (i == pkt.size() - 1);
            bus.rx_error_i  = (i == err_idx);
        end
    endtask

    // Cycle after the tlast byte: strobes are visible on return.
    task automatic end_pkt();
        @(negedge clk);
        bus.rx_tvalid_i = 1'b0;
        bus.rx_tlast_i  = 1'b0;
        bus.rx_error_i  = 1'b0;
        bus.rx_tdata_i  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.rx_tvalid_i = 1'b0;
        bus.rx_tlast_i  = 1'b0;
        bus.rx_error_i  = 1'b0;
        bus.rx_tdata_i  = 8'h00;

        // Reset state
        idle(3);
        chk("rst_ev", 32'(ev()), 32'h00);
        chk("rst_pid", 32'(bus.usb_pid_o), 32'h0);
        chk("rst_addr", 32'(bus.tok_addr_o), 32'h0);
        chk("rst_endp", 32'(bus.tok_endp_o), 32'h0);
        chk("rst_frame", 32'(bus.sof_frame_o), 32'h0);
        chk("rst_dvalid", 32'(bus.dat_tvalid_o), 32'h0);
        rst_n = 1'b1;
        idle(2);

        // SETUP addr 0 ep 0
        pkt = '{8'h2D, 8'h00, 8'h10};
        send(-1, 1'b1); end_pkt();
        chk("setup_ev", 32'(ev()), 32'h81);
        chk("setup_pid", 32'(bus.usb_pid_o), 32'hD);
        chk("setup_addr", 32'(bus.tok_addr_o), 32'h0);
        chk("setup_endp", 32'(bus.tok_endp_o), 32'h0);
        idle(1);
        chk("setup_pulse", 32'(ev()), 32'h00);

        // PING addr 0 ep 0
        pkt = '{8'hB4, 8'h00, 8'h10};
        send(-1, 1'b1); end_pkt();
        chk("ping_ev", 32'(ev()), 32'hC1);
        chk("ping_pid", 32'(bus.usb_pid_o), 32'h4);

        // OUT addr 1 ep 1
        pkt = '{8'hE1, 8'h81, 8'h58};
        send(-1, 1'b1); end_pkt();
        chk("out_ev", 32'(ev()), 32'h81);
        chk("out_pid", 32'(bus.usb_pid_o), 32'h1);
        chk("out_addr", 32'(bus.tok_addr_o), 32'h1);
        chk("out_endp", 32'(bus.tok_endp_o), 32'h1);

        // IN with corrupted CRC5: fields hold
        pkt = '{8'h69, 8'h00, 8'h11};
        send(-1, 1'b1); end_pkt();
        chk("badcrc_ev", 32'(ev()), 32'h05);
        chk("badcrc_pid", 32'(bus.usb_pid_o), 32'h9);
        chk("badcrc_addr", 32'(bus.tok_addr_o), 32'h1);
        chk("badcrc_endp", 32'(bus.tok_endp_o), 32'h1);

        // SOF frame 0x081
        pkt = '{8'hA5, 8'h81, 8'h58};
        send(-1, 1'b1); end_pkt();
        chk("sof_ev", 32'(ev()), 32'h21);
        chk("sof_frame", 32'(bus.sof_frame_o), 32'h081);
        chk("sof_addr", 32'(bus.tok_addr_o), 32'h1);

        // DATA0 with 8-byte SETUP payload
        base = dat_q.size(); tl0 = tlast_cnt;
        pkt = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
        send(-1, 1'b1); end_pkt();
        chk("data0_ev", 32'(ev()), 32'h09);
        chk("data0_tvalid", 32'(bus.dat_tvalid_o), 32'h1);
        chk("data0_tlast", 32'(bus.dat_tlast_o), 32'h1);
        chk("data0_pid", 32'(bus.usb_pid_o), 32'h3);
        idle(2);
        chk("data0_cnt", 32'(dat_q.size() - base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (base + i < dat_q.size()) chk("data0_byte", 32'(dat_q[base + i]), 32'(setup_pay[i]));
        end
        chk("data0_ntlast", 32'(tlast_cnt - tl0), 32'd1);
        chk("data0_tlast_idx", 32'(tlast_idx), 32'(base + 7));

        // Zero-length DATA1
        base = dat_q.size();
        pkt = '{8'h4B, 8'h00, 8'h00};
        send(-1, 1'b1); end_pkt();
        chk("zlp_ev", 32'(ev()), 32'h09);
        chk("zlp_pid", 32'(bus.usb_pid_o), 32'hB);
        idle(2);
        chk("zlp_cnt", 32'(dat_q.size() - base), 32'd0);

        // DATA1 with only one byte after PID
        pkt = '{8'h4B, 8'h00};
        send(-1, 1'b1); end_pkt();
        chk("short_ev", 32'(ev()), 32'h03);

        // ACK, then a bad-PID packet back-to-back
        pkt = '{8'hD2};
        send(-1, 1'b1);
        @(negedge clk);
        bus.rx_tvalid_i = 1'b1;
        bus.rx_tdata_i  = 8'h2C;
        bus.rx_tlast_i  = 1'b0;
        chk("ack_ev", 32'(ev()), 32'h11);
        chk("ack_pid", 32'(bus.usb_pid_o), 32'h2);
        pkt = '{8'h00, 8'h10};
        send(-1, 1'b1); end_pkt();
        chk("badpid_ev", 32'(ev()), 32'h01);
        chk("badpid_pid", 32'(bus.usb_pid_o), 32'h2);

        // RxError on byte 5 of DATA0
        pkt = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
        send(4, 1'b1); end_pkt();
        chk("rxerr_ev", 32'(ev()), 32'h05);

        // Oversize DATA0: 513 payload bytes, forwarding stops at 512
        idle(1);
        base = dat_q.size();
        pkt.delete();
        pkt.push_back(8'hC3);
        for (int i = 0; i < 515; i++) pkt.push_back(8'h00);
        send(-1, 1'b1); end_pkt();
        chk("big_usb_len_eop", 32'(ev() & 8'h0B), 32'h03);
        idle(2);
        chk("big_cnt", 32'(dat_q.size() - base), 32'd512);

        // Reset in the middle of a DATA0
        pkt = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01};
        send(-1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_dvalid", 32'(bus.dat_tvalid_o), 32'h0);
        chk("mrst_pid", 32'(bus.usb_pid_o), 32'h0);
        chk("mrst_addr", 32'(bus.tok_addr_o), 32'h0);
        chk("mrst_endp", 32'(bus.tok_endp_o), 32'h0);
        chk("mrst_frame", 32'(bus.sof_frame_o), 32'h0);
        bus.rx_tvalid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        base = dat_q.size();
        pkt = '{8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
        send(-1, 1'b1); end_pkt();
        chk("mrst_tail_ev", 32'(ev()), 32'h01);
        chk("mrst_tail_pid", 32'(bus.usb_pid_o), 32'h0);
        idle(2);
        chk("mrst_tail_cnt", 32'(dat_q.size() - base), 32'd0);
        pkt = '{8'h2D, 8'h01, 8'hE8};
        send(-1, 1'b1); end_pkt();
        chk("post_ev", 32'(ev()), 32'h81);
        chk("post_pid", 32'(bus.usb_pid_o), 32'hD);
        chk("post_addr", 32'(bus.tok_addr_o), 32'h1);
        chk("post_endp", 32'(bus.tok_endp_o), 32'h0);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
